// File: rtl/flght_cntrl_pkg.sv
// Shared widths, default tuning constants and saturation helper for
// flght_cntrl_pid (optional I term enabled by FLGHT_CNTRL_ITERM_EN).
package flght_cntrl_pkg;

    localparam int ERR_W  = 10;
    localparam int DIFF_W = 7;
    localparam int TERM_W = 14;
    localparam int SPD_W  = 11;

    localparam logic [SPD_W-1:0]  CAL_SPEED_DEF     = 11'h1B0;
    localparam logic [12:0]       MIN_RUN_SPEED_DEF = 13'h200;
    localparam logic signed [5:0] D_COEFF_DEF       = 6'sd7;

    // Clamp a 17-bit signed value into the range of a w-bit signed value.
    function automatic logic signed [16:0] sat(
        input logic signed [16:0] v,
        input int                 w
    );
        logic signed [16:0] hi;
        logic signed [16:0] lo;
        hi = (17'sd1 <<< (w - 1)) - 17'sd1;
        lo = -hi - 17'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/flght_axis_pd.sv
// One control axis: saturated error, delayed-derivative queue, stage-1
// registers and P/D(/I) term; I term built only with FLGHT_CNTRL_ITERM_EN.
module flght_axis_pd
    import flght_cntrl_pkg::*;
#(
    parameter int                D_QUEUE_DEPTH = 14,
    parameter logic signed [5:0] D_COEFF       = D_COEFF_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     accept,
    input  logic                     cal,
    input  logic                     iclr,
    input  logic signed [15:0]       desired,
    input  logic signed [15:0]       actual,
    output logic signed [TERM_W-1:0] term
);

    logic signed [16:0]       err_ext;
    logic signed [16:0]       err_s;
    logic signed [16:0]       diff_ext;
    logic signed [16:0]       diff_s;
    logic signed [ERR_W-1:0]  err_new;
    logic signed [DIFF_W-1:0] diff_new;
    logic signed [ERR_W-1:0]  q [D_QUEUE_DEPTH];
    logic signed [ERR_W-1:0]  err1;
    logic signed [DIFF_W-1:0] diff1;
    logic signed [TERM_W-1:0] e_ext;
    logic signed [TERM_W-1:0] p_term;
    logic signed [TERM_W-1:0] d_term;
    logic signed [TERM_W-1:0] i_term;

    always_comb begin
        err_ext  = 17'(actual) - 17'(desired);
        err_s    = sat(err_ext, ERR_W);
        err_new  = err_s[ERR_W-1:0];
        // derivative compares against the oldest entry before this push
        diff_ext = 17'(err_new) - 17'(q[D_QUEUE_DEPTH-1]);
        diff_s   = sat(diff_ext, DIFF_W);
        diff_new = diff_s[DIFF_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cal) begin
            err1  <= '0;
            diff1 <= '0;
            for (int i = 0; i < D_QUEUE_DEPTH; i++) q[i] <= '0;
        end else if (accept) begin
            err1  <= err_new;
            diff1 <= diff_new;
            q[0]  <= err_new;
            for (int i = 1; i < D_QUEUE_DEPTH; i++) q[i] <= q[i-1];
        end
    end

`ifdef FLGHT_CNTRL_ITERM_EN
    logic signed [15:0] acc;
    logic signed [16:0] acc_sum;
    logic signed [16:0] acc_s;

    always_comb begin
        acc_sum = 17'(acc) + 17'(err_new);
        acc_s   = sat(acc_sum, 16);
        i_term  = TERM_W'(acc >>> 6);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cal) acc <= '0;
        else if (accept)   acc <= iclr ? '0 : acc_s[15:0];
    end
`else
    logic unused_iclr;
    assign unused_iclr = iclr;
    assign i_term      = '0;
`endif

    always_comb begin
        e_ext  = TERM_W'(err1);
        p_term = (e_ext >>> 1) + (e_ext >>> 3);
        d_term = TERM_W'(diff1) * TERM_W'(D_COEFF);
        term   = p_term + d_term + i_term;
    end

endmodule

// File: rtl/flght_cntrl_pid.sv
// Quadcopter pitch/roll/yaw controller: three axis pipelines, motor mix,
// clamp and mode priority (FLGHT_CNTRL_ITERM_EN adds an integral term).
module flght_cntrl_pid
    import flght_cntrl_pkg::*;
#(
    parameter int                D_QUEUE_DEPTH = 14,
    parameter logic signed [5:0] D_COEFF       = D_COEFF_DEF,
    parameter logic [12:0]       MIN_RUN_SPEED = MIN_RUN_SPEED_DEF,
    parameter logic [SPD_W-1:0]  CAL_SPEED     = CAL_SPEED_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic               inertial_cal,
    input  logic signed [15:0] d_ptch,
    input  logic signed [15:0] d_roll,
    input  logic signed [15:0] d_yaw,
    input  logic signed [15:0] ptch,
    input  logic signed [15:0] roll,
    input  logic signed [15:0] yaw,
    input  logic [8:0]         thrst,
    output logic [SPD_W-1:0]   frnt_spd,
    output logic [SPD_W-1:0]   bck_spd,
    output logic [SPD_W-1:0]   lft_spd,
    output logic [SPD_W-1:0]   rght_spd,
    output logic               spd_vld
);

    logic                     accept;
    logic                     iclr;
    logic                     v1;
    logic [8:0]               thrst1;
    logic signed [TERM_W-1:0] t_ptch;
    logic signed [TERM_W-1:0] t_roll;
    logic signed [TERM_W-1:0] t_yaw;
    logic signed [15:0]       base;
    logic signed [15:0]       mix_f;
    logic signed [15:0]       mix_b;
    logic signed [15:0]       mix_l;
    logic signed [15:0]       mix_r;

    assign accept = vld & ~inertial_cal;
    assign iclr   = accept & (thrst == 9'd0);

    flght_axis_pd #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH), .D_COEFF(D_COEFF)) u_ptch (
        .clk(clk), .rst_n(rst_n), .accept(accept), .cal(inertial_cal),
        .iclr(iclr), .desired(d_ptch), .actual(ptch), .term(t_ptch)
    );

    flght_axis_pd #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH), .D_COEFF(D_COEFF)) u_roll (
        .clk(clk), .rst_n(rst_n), .accept(accept), .cal(inertial_cal),
        .iclr(iclr), .desired(d_roll), .actual(roll), .term(t_roll)
    );

    flght_axis_pd #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH), .D_COEFF(D_COEFF)) u_yaw (
        .clk(clk), .rst_n(rst_n), .accept(accept), .cal(inertial_cal),
        .iclr(iclr), .desired(d_yaw), .actual(yaw), .term(t_yaw)
    );

    // thrust travels with its sample so the mix uses the sampled value
    always_ff @(posedge clk) begin
        if (!rst_n || inertial_cal) begin
            v1     <= 1'b0;
            thrst1 <= '0;
        end else begin
            v1 <= accept;
            if (accept) thrst1 <= thrst;
        end
    end

    function automatic logic [SPD_W-1:0] clamp(input logic signed [15:0] v);
        if (v < 16'sd0)    return '0;
        if (v > 16'sd2047) return '1;
        return v[SPD_W-1:0];
    endfunction

    always_comb begin
        base  = $signed({3'b000, MIN_RUN_SPEED}) + $signed({7'b0, thrst1});
        mix_f = base + 16'(t_ptch) - 16'(t_yaw);
        mix_b = base - 16'(t_ptch) - 16'(t_yaw);
        mix_l = base + 16'(t_roll) + 16'(t_yaw);
        mix_r = base - 16'(t_roll) + 16'(t_yaw);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frnt_spd <= '0;
            bck_spd  <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else if (inertial_cal) begin
            frnt_spd <= CAL_SPEED;
            bck_spd  <= CAL_SPEED;
            lft_spd  <= CAL_SPEED;
            rght_spd <= CAL_SPEED;
            spd_vld  <= 1'b0;
        end else if (v1) begin
            spd_vld <= 1'b1;
            if (thrst1 == 9'd0) begin
                frnt_spd <= '0;
                bck_spd  <= '0;
                lft_spd  <= '0;
                rght_spd <= '0;
            end else begin
                frnt_spd <= clamp(mix_f);
                bck_spd  <= clamp(mix_b);
                lft_spd  <= clamp(mix_l);
                rght_spd <= clamp(mix_r);
            end
        end else begin
            spd_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flght_cntrl_pid.sv
// Scoreboard bench for flght_cntrl_pid: a reference model predicts each
// sample's speeds and output cycle; the spd_vld monitor pops and compares.
module tb_flght_cntrl_pid;

    localparam int DQ = 14;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               vld = 1'b0;
    logic               inertial_cal = 1'b0;
    logic signed [15:0] d_ptch = '0;
    logic signed [15:0] d_roll = '0;
    logic signed [15:0] d_yaw = '0;
    logic signed [15:0] ptch = '0;
    logic signed [15:0] roll = '0;
    logic signed [15:0] yaw = '0;
    logic [8:0]         thrst = '0;
    logic [10:0]        frnt_spd;
    logic [10:0]        bck_spd;
    logic [10:0]        lft_spd;
    logic [10:0]        rght_spd;
    logic               spd_vld;

    flght_cntrl_pid dut (
        .clk(clk), .rst_n(rst_n), .vld(vld), .inertial_cal(inertial_cal),
        .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
        .ptch(ptch), .roll(roll), .yaw(yaw), .thrst(thrst),
        .frnt_spd(frnt_spd), .bck_spd(bck_spd),
        .lft_spd(lft_spd), .rght_spd(rght_spd), .spd_vld(spd_vld)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int f;
        int b;
        int l;
        int r;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   mq[3][DQ];
    int   macc[3];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sat(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int clampv(input int v);
        return sat(v, 0, 2047);
    endfunction

    task automatic model_clear();
        for (int a = 0; a < 3; a++) begin
            macc[a] = 0;
            for (int i = 0; i < DQ; i++) mq[a][i] = 0;
        end
    endtask

    task automatic model_push(input int dp, input int dr, input int dy,
                              input int p, input int r, input int y,
                              input int thr, input int due);
        int   des[3];
        int   act[3];
        int   t[3];
        int   err;
        int   diff;
        int   iterm;
        int   base;
        exp_t x;
        des = '{dp, dr, dy};
        act = '{p, r, y};
        for (int a = 0; a < 3; a++) begin
            err  = sat(act[a] - des[a], -512, 511);
            diff = sat(err - mq[a][DQ-1], -64, 63);
            for (int i = DQ - 1; i > 0; i--) mq[a][i] = mq[a][i-1];
            mq[a][0] = err;
            iterm = 0;
`ifdef FLGHT_CNTRL_ITERM_EN
            if (thr == 0) macc[a] = 0;
            else macc[a] = sat(macc[a] + err, -32768, 32767);
            iterm = macc[a] >>> 6;
`endif
            t[a] = (err >>> 1) + (err >>> 3) + diff * 7 + iterm;
        end
        base = 512 + thr;
        if (thr == 0) begin
            x.f = 0; x.b = 0; x.l = 0; x.r = 0;
        end else begin
            x.f = clampv(base + t[0] - t[2]);
            x.b = clampv(base - t[0] - t[2]);
            x.l = clampv(base + t[1] + t[2]);
            x.r = clampv(base - t[1] + t[2]);
        end
        x.due = due;
        sb.push_back(x);
    endtask

    task automatic drive(input logic v, input logic c, input logic rs,
                         input int dp, input int dr, input int dy,
                         input int p, input int r, input int y, input int thr);
        @(posedge clk);
        #1;
        vld = v;
        inertial_cal = c;
        rst_n = rs;
        d_ptch = 16'(dp);
        d_roll = 16'(dr);
        d_yaw = 16'(dy);
        ptch = 16'(p);
        roll = 16'(r);
        yaw = 16'(y);
        thrst = 9'(thr);
        if (!rs || c) begin
            model_clear();
            while (sb.size() > 0 && sb[sb.size()-1].due > cyc)
                void'(sb.pop_back());
        end else if (v) begin
            model_push(dp, dr, dy, p, r, y, thr, cyc + 2);
        end
    endtask

    task automatic samp(input int p, input int r, input int y, input int thr);
        drive(1'b1, 1'b0, 1'b1, 0, 0, 0, p, r, y, thr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_frnt", frnt_spd, 0);
        chk("rst_rght", rght_spd, 0);
        chk("rst_vld", spd_vld, 0);
    endtask

    task automatic chk4(input string tag, input int f, input int b,
                        input int l, input int r);
        chk({tag, "_frnt"}, frnt_spd, f);
        chk({tag, "_bck"}, bck_spd, b);
        chk({tag, "_lft"}, lft_spd, l);
        chk({tag, "_rght"}, rght_spd, r);
    endtask

    always @(negedge clk) begin
        if (spd_vld === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_vld", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_cycle", cyc, e.due);
                chk("sb_frnt", frnt_spd, e.f);
                chk("sb_bck", bck_spd, e.b);
                chk("sb_lft", lft_spd, e.l);
                chk("sb_rght", rght_spd, e.r);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("missed_vld", 0, 1);
            void'(sb.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();

        // neutral sample and exact pulse timing
        do_reset();
        samp(0, 0, 0, 256);
        idle(1);
        chk("t1_early_vld", spd_vld, 0);
        idle(1);
        chk("t1_vld", spd_vld, 1);
        chk4("t1", 768, 768, 768, 768);
        idle(1);
        chk("t1_vld_off", spd_vld, 0);
        chk("t1_hold", frnt_spd, 768);

        // pitch step
        do_reset();
        samp(100, 0, 0, 256);
        idle(3);
`ifdef FLGHT_CNTRL_ITERM_EN
        chk4("t2", 1272, 264, 768, 768);
`else
        chk4("t2", 1271, 265, 768, 768);
`endif

`ifdef FLGHT_CNTRL_ITERM_EN
        // integrator saturates without wrap: I=511, D=0 after queue fills
        for (int i = 0; i < 500; i++) samp(100, 0, 0, 256);
        idle(3);
        chk("t6_frnt", frnt_spd, 1341);
        chk("t6_bck", bck_spd, 195);
`endif

        // saturation and output clamp
        do_reset();
        samp(32767, 0, -32768, 511);
        idle(3);
`ifndef FLGHT_CNTRL_ITERM_EN
        chk4("t3", 2047, 1032, 255, 255);
`endif

        // D queue depth: D vanishes once the first error reaches the tail
        do_reset();
        for (int i = 0; i < 16; i++) samp(10, 0, 0, 256);
        idle(3);
`ifndef FLGHT_CNTRL_ITERM_EN
        chk("t4_frnt_last", frnt_spd, 774);
        chk("t4_bck_last", bck_spd, 762);
`endif

        // calibration with vld wins
        do_reset();
        samp(20, 0, 0, 256);
        idle(3);
        drive(1'b1, 1'b1, 1'b1, 0, 0, 0, 50, 0, 0, 256);
        drive(1'b1, 1'b1, 1'b1, 0, 0, 0, 50, 0, 0, 256);
        chk("t5_cal_vld", spd_vld, 0);
        chk4("t5_cal", 432, 432, 432, 432);
        idle(3);
        chk("t5_cal_hold", frnt_spd, 432);

        // zero thrust
        samp(50, 20, 10, 0);
        idle(3);
        chk4("t5_zero", 0, 0, 0, 0);

        // calibration squashes an in-flight sample
        samp(30, 0, 0, 256);
        drive(1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        chk("t5_squash", frnt_spd, 432);

        // reset during stage 1 drops the sample
        samp(30, 0, 0, 256);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("t5_rst_vld", spd_vld, 0);
        chk("t5_rst_frnt", frnt_spd, 0);
        idle(2);
        chk("t5_rst_vld2", spd_vld, 0);

        // random traffic including back-to-back and calibration blips
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int thr;
            thr = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 511);
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
                  1'b1,
                  $urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000,
                  $urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000,
                  $urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000,
                  thr);
        end
        idle(4);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
